// File: rtl/multiply_seq_board_pkg.sv
// ============================================================================
// Module   : multiply_seq_board_pkg
// Purpose  : Shared declarations for the board's sequential arithmetic engines.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multiply_seq_board_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned c_DEFAULT_WIDTH = 16;
    localparam int unsigned c_DISP_WIDTH    = 16;

endpackage

`default_nettype wire

// File: rtl/mult_seq_datapath.sv
// ============================================================================
// Module   : mult_seq_datapath
// Purpose  : Shift-and-add datapath (acc/mcand/mplier, WIDTH+1-bit adder, shifter).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_seq_datapath
    import multiply_seq_board_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [SHW-1:0]       i_shamt,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic                 o_rest_zero
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_wide;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_wide = {w_sum, r_acc[WIDTH-1:0]};

    // The shift is always at least one, so dropping bit 0 first keeps the carry.
    assign w_acc_next = w_wide[2*WIDTH:1] >> (i_shamt - SHW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_acc       = r_acc;
    assign o_rest_zero = ~|r_mplier[WIDTH-1:1];

endmodule

`default_nettype wire

// File: rtl/multiply_seq_board.sv
// ============================================================================
// Module   : multiply_seq_board
// Purpose  : Sequential unsigned multiplier, start/done handshake, one bit/clock.
//            Optional MULT_SEQ_EARLY_EXIT_EN ends CALC once mplier runs out of ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multiply_seq_board
    import multiply_seq_board_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   y,
    output logic [WIDTH-1:0]     y_low,
    output logic                 ovf
);

    localparam int unsigned c_CW = $clog2(WIDTH);
    localparam int unsigned c_SW = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CW-1:0]    r_cnt;
    logic               w_load;
    logic               w_step;
    logic               w_fin;
    logic               w_last;
    logic               w_exit_early;
    logic [c_SW-1:0]    w_shamt;
    logic [2*WIDTH-1:0] w_acc;

    logic [2*WIDTH-1:0] r_y;
    logic               r_done;
    logic               r_busy;
    logic               r_ovf;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    logic w_rest_zero;
    assign w_exit_early = w_rest_zero;
    // Early exit folds all remaining right shifts into the final step.
    assign w_shamt      = w_exit_early ? (c_SW'(WIDTH) - c_SW'(r_cnt)) : c_SW'(1);
`else
    assign w_exit_early = 1'b0;
    assign w_shamt      = c_SW'(1);
`endif

    assign w_last = (r_cnt == c_CW'(WIDTH - 1)) || w_exit_early;

    mult_seq_datapath #(
        .WIDTH (WIDTH),
        .SHW   (c_SW)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_shamt     (w_shamt),
        .i_a         (a),
        .i_b         (b),
        .o_acc       (w_acc),
`ifdef MULT_SEQ_EARLY_EXIT_EN
        .o_rest_zero (w_rest_zero)
`else
        .o_rest_zero ()
`endif
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fin        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_fin        = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load || (w_step && w_last)) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    // Registered result stage: y, ovf and done all change on the same edge,
    // and busy covers the done cycle so it falls together with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y    <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= w_fin;
            r_busy <= (w_state_next != IDLE) || w_fin;
            if (w_fin) begin
                r_y   <= w_acc;
                r_ovf <= |w_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign y     = r_y;
    assign y_low = r_y[WIDTH-1:0];
    assign ovf   = r_ovf;
    assign done  = r_done;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_multiply_seq_board.sv
// ============================================================================
// Module   : tb_multiply_seq_board
// Purpose  : Scoreboard bench for multiply_seq_board (directed + random products).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multiply_seq_board;

    localparam int W = 16;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] y;
    logic [W-1:0]   y_low;
    logic           ovf;

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc_cyc;
        int             lat;
    } exp_t;

    exp_t           q[$];
    exp_t           e;
    int             cyc      = 0;
    int             n_vec    = 0;
    int             n_err    = 0;
    logic           prev_done = 1'b0;
    logic           prev_rst  = 1'b1;
    logic [2*W-1:0] prev_y    = '0;

    multiply_seq_board #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .y_low (y_low),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Latency taken straight from the operand: fixed WIDTH+1, or 2 + msb index of b.
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        int msb = 0;
        for (int i = 0; i < W; i++) if (bv[i]) msb = i;
        return 2 + msb;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [2*W-1:0] product(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, av};
        wb = {{W{1'b0}}, bv};
        return wa * wb;
    endfunction

    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t t;
        t.prod    = product(av, bv);
        t.acc_cyc = cyc + 1;
        t.lat     = exp_lat(bv);
        q.push_back(t);
    endtask

    // The engine is ready to accept on the next edge when idle or in its done cycle.
    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy || done) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL ready_timeout: got busy=%0b required ready within 200 cycles", busy);
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        wait_ready();
        a     = av;
        b     = bv;
        start = 1'b1;
        push_exp(av, bv);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(1);
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops one expectation per done pulse and checks result and latency.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_rst  = 1'b1;
                prev_done = 1'b0;
                prev_y    = y;
            end else begin
                if (done) begin
                    check("done_one_cycle", {63'd0, prev_done}, 64'd0);
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_done: got done=1 required no done without request");
                    end else begin
                        e = q.pop_front();
                        check("y", {32'd0, y}, {32'd0, e.prod});
                        check("y_low", {48'd0, y_low}, {48'd0, e.prod[W-1:0]});
                        check("ovf", {63'd0, ovf}, {63'd0, |e.prod[2*W-1:W]});
                        check("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    end
                end else if (!prev_rst) begin
                    check("y_hold", {32'd0, y}, {32'd0, prev_y});
                end
                prev_rst  = 1'b0;
                prev_done = done;
                prev_y    = y;
            end
        end
    end

    initial begin
        @(negedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_y", {32'd0, y}, 64'd0);
        check("rst_y_low", {48'd0, y_low}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        rst = 1'b0;

        issue(16'd123, 16'd45);
        issue(16'hFFFF, 16'hFFFF);
        issue(16'd0, 16'hFFFF);
        issue(16'd1000, 16'd5);
        issue(16'd77, 16'd0);
        issue(16'hFFFF, 16'd1);

        // Start raised mid-calculation must be dropped, not queued.
        issue(16'd7, 16'd9);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        repeat (1) @(negedge clk);
`else
        repeat (4) @(negedge clk);
`endif
        a     = 16'd100;
        b     = 16'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Abort: reset partway through, then a clean request.
        issue(16'd300, 16'd200);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        q.delete();
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_y", {32'd0, y}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(16'd2, 16'd3);

        // Start held high: each return to idle accepts the operands on the bus.
        a     = rand_op();
        b     = rand_op();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            push_exp(a, b);
            @(negedge clk);
            a = rand_op();
            b = rand_op();
        end
        start = 1'b0;

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(rand_op(), rand_op());
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending results required 0", q.size());
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
